spi_move_slave: RTL and testbench

//   SPI slave (mode 0: CPOL=0, CPHA=0, MSB first) receiving move frames from the external

---
 rtl/spi_move_slave.sv | 165 ++++++++++++++++
 tb/tb_spi_move_slave.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spi_move_slave.sv
// SPI mode-0 slave that receives move frames from the external controller.
// Decodes {opcode, index} frames into move_valid/move_err pulses and returns
// one status byte on miso per frame.
//
// state | meaning
// IDLE  | waiting for ss to fall; miso released
// SHIFT | frame in progress; sampling mosi on sclk rise, driving miso on fall
// DONE  | full frame received; extra sclk edges ignored until ss rises
module spi_move_slave #(
  parameter int DATA_W      = 8,
  parameter int IDX_W       = 6,
  parameter int NUM_CELLS   = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [IDX_W-1:0]  move_index,
  output logic              move_valid,
  output logic              move_err,
  output logic              frame_abort
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] CELL_LIMIT = IDX_W'(NUM_CELLS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_d, ss_d;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-2:0] tx_shift;
  logic              miso_r;
  logic              frame_done;
  logic              is_move;
  logic              idx_ok;
  logic              last_bit;

  // Synchronise the SPI pins into clk. ss resets low so that a master already
  // holding ss low at reset release cannot start a frame until it goes high first.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign last_bit  = (bit_cnt == LAST_BIT);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; an ss rise always takes precedence over sclk edges.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (ss_fall) state_nxt = SHIFT;
      SHIFT: begin
        if (ss_rise)                     state_nxt = IDLE;
        else if (sclk_rise && last_bit)  state_nxt = DONE;
      end
      DONE:  if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift registers, bit counter, miso driver and frame completion/abort flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      miso_r      <= 1'b0;
      rx_data     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          miso_r <= 1'b0;
          if (ss_fall) begin
            tx_shift <= tx_data[DATA_W-2:0];
            miso_r   <= tx_data[DATA_W-1];
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            frame_abort <= 1'b1;
            miso_r      <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
              rx_data    <= {rx_shift, mosi_s};
              frame_done <= 1'b1;
              miso_r     <= 1'b0;
            end
          end else if (sclk_fall) begin
            miso_r   <= tx_shift[DATA_W-2];
            tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
          end
        end
        default: miso_r <= 1'b0;
      endcase
    end
  end

  assign is_move = (rx_data[DATA_W-1:DATA_W-2] == 2'b01);
  assign idx_ok  = (rx_data[IDX_W-1:0] < CELL_LIMIT);

  // Decode the captured frame one clk after it lands in rx_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid   <= 1'b0;
      move_valid <= 1'b0;
      move_err   <= 1'b0;
      move_index <= '0;
    end else begin
      rx_valid   <= frame_done;
      move_valid <= frame_done & is_move & idx_ok;
      move_err   <= frame_done & is_move & ~idx_ok;
      if (frame_done && is_move && idx_ok) move_index <= rx_data[IDX_W-1:0];
    end
  end

  assign miso_oe = (state != IDLE);
  assign miso    = miso_r & miso_oe;

endmodule

// File: tb/tb_spi_move_slave.sv
// Directed bench for spi_move_slave: table of frames plus reset corner cases.
module tb_spi_move_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       ss = 1'b0;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, miso_oe, rx_valid, move_valid, move_err, frame_abort;
  logic [7:0] rx_data;
  logic [5:0] move_index;

  spi_move_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .rx_data(rx_data),
    .rx_valid(rx_valid), .move_index(move_index), .move_valid(move_valid),
    .move_err(move_err), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  int n_rxv = 0, n_mv = 0, n_me = 0, n_ab = 0;
  int checks = 0, passes = 0;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid)    n_rxv++;
    if (move_valid)  n_mv++;
    if (move_err)    n_me++;
    if (frame_abort) n_ab++;
  end

  typedef struct {
    logic [15:0] w;
    int          n;
    logic [7:0]  tx;
    int          gap;
    logic [7:0]  exp_rx;
    int          exp_rxv, exp_mv, exp_me, exp_ab;
    logic [5:0]  exp_idx;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic sbit(input logic b, output logic m);
    mosi = b;
    half();
    sclk = 1'b1;
    m = miso;
    half();
    sclk = 1'b0;
  endtask

  task automatic do_frame(input logic [15:0] w, input int n, input logic [7:0] tx,
                          output logic [15:0] cap);
    logic m;
    tx_data = tx;
    @(negedge clk);
    ss  = 1'b0;
    cap = '0;
    for (int i = 0; i < n; i++) begin
      sbit(w[n-1-i], m);
      cap = {cap[14:0], m};
    end
    half();
    ss   = 1'b1;
    mosi = 1'b0;
  endtask

  initial begin
    logic [15:0] cap, exp_miso;
    logic        m;
    int b_rxv, b_mv, b_me, b_ab;

    //          w       n   tx     gap rx     rxv mv me ab idx
    vecs[0]  = '{16'h044, 8, 8'hA5, 20, 8'h44, 1, 1, 0, 0, 6'd4};
    vecs[1]  = '{16'h04C, 8, 8'h3C, 20, 8'h4C, 1, 0, 1, 0, 6'd4};
    vecs[2]  = '{16'h0C3, 8, 8'h00, 20, 8'hC3, 1, 0, 0, 0, 6'd4};
    vecs[3]  = '{16'h008, 5, 8'h81, 20, 8'hC3, 0, 0, 0, 1, 6'd4};
    vecs[4]  = '{16'h041, 8, 8'hFF, 20, 8'h41, 1, 1, 0, 0, 6'd1};
    vecs[5]  = '{16'h11F, 10, 8'h5A, 4, 8'h47, 1, 1, 0, 0, 6'd7};
    vecs[6]  = '{16'h048, 8, 8'h0F, 4, 8'h48, 1, 1, 0, 0, 6'd8};
    vecs[7]  = '{16'h049, 8, 8'hF0, 20, 8'h49, 1, 0, 1, 0, 6'd8};
    vecs[8]  = '{16'h040, 8, 8'h81, 20, 8'h40, 1, 1, 0, 0, 6'd0};
    vecs[9]  = '{16'h003, 8, 8'h66, 20, 8'h03, 1, 0, 0, 0, 6'd0};
    vecs[10] = '{16'h045, 8, 8'h00, 20, 8'h45, 1, 1, 0, 0, 6'd5};
    vecs[11] = '{16'h07F, 8, 8'hC9, 20, 8'h7F, 1, 0, 1, 0, 6'd5};

    // Reset held with ss low and sclk toggling.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sclk = ~sclk;
      check("reset_outputs",
            32'({miso, miso_oe, rx_data, rx_valid, move_index, move_valid, move_err, frame_abort}),
            32'd0);
    end
    @(negedge clk);
    sclk = 1'b0;
    rst  = 1'b0;

    // ss never seen high since reset: clocking a frame must not start one.
    for (int i = 0; i < 8; i++) sbit(i[0], m);
    half();
    check("no_frame_after_reset_rxv", 32'(n_rxv + n_ab), 32'd0);
    check("no_frame_after_reset_oe", 32'({miso_oe, miso}), 32'd0);
    ss = 1'b1;
    repeat (10) @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      b_rxv = n_rxv; b_mv = n_mv; b_me = n_me; b_ab = n_ab;
      do_frame(vecs[v].w, vecs[v].n, vecs[v].tx, cap);
      repeat (vecs[v].gap) @(negedge clk);
      if (vecs[v].n <= 8) exp_miso = 16'(vecs[v].tx) >> (8 - vecs[v].n);
      else                exp_miso = 16'(vecs[v].tx) << (vecs[v].n - 8);
      check($sformatf("v%0d_rx_data", v), 32'(rx_data), 32'(vecs[v].exp_rx));
      check($sformatf("v%0d_rx_valid", v), 32'(n_rxv - b_rxv), 32'(vecs[v].exp_rxv));
      check($sformatf("v%0d_move_valid", v), 32'(n_mv - b_mv), 32'(vecs[v].exp_mv));
      check($sformatf("v%0d_move_err", v), 32'(n_me - b_me), 32'(vecs[v].exp_me));
      check($sformatf("v%0d_frame_abort", v), 32'(n_ab - b_ab), 32'(vecs[v].exp_ab));
      check($sformatf("v%0d_move_index", v), 32'(move_index), 32'(vecs[v].exp_idx));
      check($sformatf("v%0d_miso_bits", v), 32'(cap), 32'(exp_miso));
      check($sformatf("v%0d_idle_miso", v), 32'({miso_oe, miso}), 32'd0);
    end

    // Reset in the middle of a frame discards it.
    b_rxv = n_rxv; b_ab = n_ab;
    tx_data = 8'hFF;
    @(negedge clk);
    ss = 1'b0;
    for (int i = 0; i < 4; i++) sbit(i == 1, m);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) sbit(i == 2, m);
    half();
    ss = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset_no_pulses", 32'((n_rxv - b_rxv) + (n_ab - b_ab)), 32'd0);
    check("midreset_rx_data", 32'(rx_data), 32'd0);
    check("midreset_move_index", 32'(move_index), 32'd0);

    b_mv = n_mv;
    do_frame(16'h042, 8, 8'h99, cap);
    repeat (20) @(negedge clk);
    check("post_reset_rx_data", 32'(rx_data), 32'h42);
    check("post_reset_move_valid", 32'(n_mv - b_mv), 32'd1);
    check("post_reset_move_index", 32'(move_index), 32'd2);
    check("post_reset_miso_bits", 32'(cap), 32'h99);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
